// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between the MIPS fetch and load/store ports:
// data-priority arbitration with a fetch starvation guard, plus byte-lane steering.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_err,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] CNT_INIT   = LW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_WRITE = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   lane_be = 4'b0001 << a;
            2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic sgn,
                                                 input logic [1:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (sz)
            2'b00:   load_extract = {{24{sgn & b[7]}}, b};
            2'b01:   load_extract = {{16{sgn & h[15]}}, h};
            default: load_extract = rd;
        endcase
    endfunction

    state_t         r_state, w_state_nxt;
    logic [SW-1:0]  r_starve, w_starve_nxt;
    logic [LW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_own_d, w_own_d_nxt;
    logic [1:0]     r_size, w_size_nxt;
    logic           r_signed, w_signed_nxt;
    logic [1:0]     r_lane, w_lane_nxt;

    logic           r_i_gnt, w_i_gnt;
    logic           r_i_rvalid, w_i_rvalid;
    logic [31:0]    r_i_rdata, w_i_rdata;
    logic           r_d_gnt, w_d_gnt;
    logic           r_d_err, w_d_err;
    logic           r_d_rvalid, w_d_rvalid;
    logic [31:0]    r_d_rdata, w_d_rdata;
    logic           r_m_en, w_m_en;
    logic           r_m_we, w_m_we;
    logic [3:0]     r_m_be, w_m_be;
    logic [31:0]    r_m_addr, w_m_addr;
    logic [31:0]    r_m_wdata, w_m_wdata;

    logic           w_sample;
    logic           w_pick_d;
    logic           w_pick_i;
    logic           w_unused;

    assign w_unused = ^i_addr[1:0];
    assign w_sample = (r_state == S_IDLE) || (r_state == S_RESP);

    // Next-state, arbitration and next-output logic; all outputs are registered from here.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        w_cnt_nxt    = r_cnt;
        w_own_d_nxt  = r_own_d;
        w_size_nxt   = r_size;
        w_signed_nxt = r_signed;
        w_lane_nxt   = r_lane;
        w_i_gnt      = 1'b0;
        w_i_rvalid   = 1'b0;
        w_i_rdata    = r_i_rdata;
        w_d_gnt      = 1'b0;
        w_d_err      = 1'b0;
        w_d_rvalid   = 1'b0;
        w_d_rdata    = r_d_rdata;
        w_m_en       = 1'b0;
        w_m_we       = 1'b0;
        w_m_be       = 4'b0000;
        w_m_addr     = 32'h0000_0000;
        w_m_wdata    = 32'h0000_0000;
        w_pick_d     = 1'b0;
        w_pick_i     = 1'b0;

        // Data wins unless fetch has already lost STARVE_MAX contested rounds in a row.
        if (w_sample) begin
            if (d_req && (!i_req || (r_starve < STARVE_LIM))) begin
                w_pick_d = 1'b1;
                if (i_req) begin
                    w_starve_nxt = r_starve + 1'b1;
                end else begin
                    w_starve_nxt = r_starve;
                end
            end else if (i_req) begin
                w_pick_i     = 1'b1;
                w_starve_nxt = '0;
            end else begin
                w_starve_nxt = r_starve;
            end
        end else begin
            w_starve_nxt = r_starve;
        end

        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_pick_d) begin
                    w_own_d_nxt  = 1'b1;
                    w_size_nxt   = d_size;
                    w_signed_nxt = d_signed;
                    w_lane_nxt   = d_addr[1:0];
                    w_d_gnt      = 1'b1;
                    if (misaligned(d_size, d_addr[1:0])) begin
                        w_state_nxt = S_ERR;
                        w_d_err     = 1'b1;
                    end else if (d_we) begin
                        w_state_nxt = S_WRITE;
                        w_m_en      = 1'b1;
                        w_m_we      = 1'b1;
                        w_m_be      = lane_be(d_size, d_addr[1:0]);
                        w_m_addr    = {d_addr[31:2], 2'b00};
                        w_m_wdata   = lane_wdata(d_size, d_wdata);
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_m_en      = 1'b1;
                        w_m_be      = 4'b1111;
                        w_m_addr    = {d_addr[31:2], 2'b00};
                    end
                end else if (w_pick_i) begin
                    w_own_d_nxt = 1'b0;
                    w_i_gnt     = 1'b1;
                    w_state_nxt = S_ISSUE;
                    w_m_en      = 1'b1;
                    w_m_be      = 4'b1111;
                    w_m_addr    = {i_addr[31:2], 2'b00};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = CNT_INIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                    if (r_own_d) begin
                        w_d_rvalid = 1'b1;
                        w_d_rdata  = load_extract(r_size, r_signed, r_lane, m_rdata);
                    end else begin
                        w_i_rvalid = 1'b1;
                        w_i_rdata  = m_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WRITE, S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, captured request attributes and registered outputs; reset abandons any read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_starve   <= '0;
            r_cnt      <= '0;
            r_own_d    <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_lane     <= 2'b00;
            r_i_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= 32'h0000_0000;
            r_d_gnt    <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= 32'h0000_0000;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_be     <= 4'b0000;
            r_m_addr   <= 32'h0000_0000;
            r_m_wdata  <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_starve   <= w_starve_nxt;
            r_cnt      <= w_cnt_nxt;
            r_own_d    <= w_own_d_nxt;
            r_size     <= w_size_nxt;
            r_signed   <= w_signed_nxt;
            r_lane     <= w_lane_nxt;
            r_i_gnt    <= w_i_gnt;
            r_i_rvalid <= w_i_rvalid;
            r_i_rdata  <= w_i_rdata;
            r_d_gnt    <= w_d_gnt;
            r_d_err    <= w_d_err;
            r_d_rvalid <= w_d_rvalid;
            r_d_rdata  <= w_d_rdata;
            r_m_en     <= w_m_en;
            r_m_we     <= w_m_we;
            r_m_be     <= w_m_be;
            r_m_addr   <= w_m_addr;
            r_m_wdata  <= w_m_wdata;
        end
    end

    assign i_gnt    = r_i_gnt;
    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_gnt    = r_d_gnt;
    assign d_err    = r_d_err;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign m_en     = r_m_en;
    assign m_we     = r_m_we;
    assign m_be     = r_m_be;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the MIPS instruction-fetch port and the load/store data port. It sits between the `mips` core and a unified memory, and replaces the separate imem/dmem pair in the top level. It converts byte, half and word accesses (sb/sh/sw, lb/lbu/lh/lhu/lw) into word-aligned memory cycles with byte enables. It serialises fetch and data traffic with data priority and a starvation guard for fetch.

## Interface

**Parameters**
- `MEM_LAT`, default 2: cycles from `m_en` to valid `m_rdata`; minimum 1.
- `STARVE_MAX`, default 4: consecutive fetch losses after which fetch wins; minimum 1.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `i_req` in 1: fetch request; held with `i_addr` until `i_gnt`.
- `i_addr` in 32: fetch address; bits [1:0] are ignored.
- `i_gnt` out 1: one-cycle pulse, fetch issued to memory.
- `i_rvalid` out 1: one-cycle pulse, `i_rdata` valid.
- `i_rdata` out 32: fetched word.
- `d_req` in 1: data request; held with `d_we`, `d_size`, `d_signed`, `d_addr`, `d_wdata` until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `d_signed` in 1: sign-extend load result (lb/lh); 0 = zero-extend.
- `d_addr` in 32: byte address.
- `d_wdata` in 32: store data, right-justified.
- `d_gnt` out 1: one-cycle pulse, data request accepted (issued or errored).
- `d_err` out 1: one-cycle pulse with `d_gnt`, misaligned access, no memory cycle.
- `d_rvalid` out 1: one-cycle pulse, `d_rdata` valid.
- `d_rdata` out 32: extracted and extended load data.
- `m_en` out 1: memory cycle strobe.
- `m_we` out 1: memory write.
- `m_be` out 4: byte enables; bit n enables byte lane [8n+7:8n].
- `m_addr` out 32: word address; `m_addr[1:0]` = 00.
- `m_wdata` out 32: lane-replicated write data.
- `m_rdata` in 32: memory read data, valid `MEM_LAT` cycles after `m_en`.

## Operation

**FSM states**
- **IDLE**: requests sampled at each rising edge.
  - `d_req` alone, or both requests with starve count < `STARVE_MAX` → data wins. If both were requesting, starve count +1, saturating at `STARVE_MAX`.
  - `i_req` alone, or both with starve count = `STARVE_MAX` → fetch wins; starve count ← 0.
  - A winning load or fetch → ISSUE. A winning store → WRITE. A misaligned data winner → ERR.
- **ISSUE** (1 cycle):
  - `m_en`=1, `m_we`=0, `m_be`=1111; the winner's `*_gnt`=1.
  - Latency counter loaded; next state WAIT.
- **WAIT**: counter runs until `m_rdata` is valid, then registers the result → RESP.
- **RESP** (1 cycle): `*_rvalid`=1 for the owner. Requests are sampled at the end of this cycle exactly as in IDLE (back-to-back reads allowed).
- **WRITE** (1 cycle): `m_en`=`m_we`=`d_gnt`=1 → IDLE.
- **ERR** (1 cycle): `d_gnt`=`d_err`=1, no `m_en` → IDLE.

**Alignment.** Misaligned means half with `d_addr[0]`=1, or word with `d_addr[1:0]`≠00. Fetch is never misaligned; its low bits are masked.

**Byte lanes** (little-endian)
- Byte: `m_be` = 0001 << `addr[1:0]`; `m_wdata` = {4{wdata[7:0]}}.
- Half: `m_be` = `addr[1]` ? 1100 : 0011; `m_wdata` = {2{wdata[15:0]}}.
- Word: `m_be` = 1111; `m_wdata` = `d_wdata`.
- Loads: the selected lane(s) are right-justified, then extended per the `d_signed` value captured at grant.

**Capture.** Address, size and sign flags are captured at grant. Requester inputs may change after `*_gnt`.

## Timing

- **Reset**: asynchronous. State → IDLE, starve count 0, latency counter 0. All outputs 0, including `i_rdata` and `d_rdata`.
- **Reset mid-operation**: an outstanding read is abandoned; no `rvalid` is produced after reset releases.
- **Read latency**: request sampled at edge k → `m_en`/`gnt` in cycle k+1 → `rvalid` in cycle k+2+`MEM_LAT`.
- **Read throughput**: one read per `MEM_LAT`+2 cycles.
- **Store**: `m_en`/`d_gnt` in cycle k+1; next sampling at edge k+2.
- **Misaligned**: `d_gnt`/`d_err` in cycle k+1; no memory access.
- At most one outstanding access; all other requests stall until RESP, WRITE or ERR completes.
- All `*_gnt`, `*_rvalid` and `d_err` outputs are single-cycle pulses.
- `i_gnt` and `d_gnt` are never high in the same cycle.

## Test plan

- **Reset then fetch.** Reset then `i_req`, `i_addr`=0x40, `m_rdata`=0x8C020004, `MEM_LAT`=2.
  - `i_gnt` in cycle 1 with `m_addr`=0x40, `m_be`=1111.
  - `i_rvalid` in cycle 4 with `i_rdata`=0x8C020004.
- **sb.** `d_we`=1, `d_size`=00, `d_addr`=0x53, `d_wdata`=0x000000AB.
  - `m_addr`=0x50, `m_be`=1000, `m_wdata`=0xABABABAB, one cycle with `m_en`=`m_we`=1.
- **lb / lbu.** `d_addr`=0x51, `m_rdata`=0x1234F678.
  - `d_signed`=1 → `d_rdata`=0xFFFFFFF6.
  - `d_signed`=0 → `d_rdata`=0x000000F6.
- **lh.** `d_addr`=0x52, `d_signed`=1, `m_rdata`=0x80017FFF → `d_rdata`=0xFFFF8001.
- **Starvation guard.** `i_req` and `d_req` both held continuously, `STARVE_MAX`=4.
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - `i_gnt` and `d_gnt` are never high together.
- **Misaligned word, then reset mid-read.**
  - Word at `d_addr`=0x62 → `d_gnt`=`d_err`=1, no `m_en`.
  - Then assert `reset` during WAIT of a load → all outputs 0 and no `d_rvalid` afterwards.
